// File: rtl/pipe_scoreboard.sv
// ---------------------------------------------------------------------------
// pipe_scoreboard
//
// Hazard scoreboard for the in-order pipeline. It tracks the destination
// register of every instruction in the DEPTH stages after ID. For each
// source operand it tells ID which stage to forward from, and it raises a
// stall for load-use hazards. A branch flush squashes the younger tracked
// instructions. A saturating counter records the number of stall cycles.
//
// Ports
//   clk_i          clock; all state updates on the rising edge
//   rst_i          synchronous active-high reset
//   id_valid_i     ID holds a real instruction
//   id_rs_i/rt_i   source register addresses
//   id_use_rs_i/rt_i  the instruction reads that operand
//   id_wen_i       the instruction writes a register
//   id_waddr_i     destination register
//   id_is_load_i   the instruction is a load
//   flush_i        branch taken; squash stages 1..FLUSH_STAGES
//   stall_o        hold PC and IFID, insert a bubble into EX
//   fwd_rs_o/rt_o  0 = register file, k = forward from stage k
//   inflight_o     registered count of valid tracked entries
//   stall_cnt_o    saturating count of cycles with stall_o = 1
// ---------------------------------------------------------------------------
module pipe_scoreboard #(
    parameter int DEPTH        = 3,
    parameter int ADDR_W       = 5,
    parameter int LOAD_READY   = 2,
    parameter int FLUSH_STAGES = 2,
    parameter int CNT_W        = 16,
    localparam int SEL_W       = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [ADDR_W-1:0] id_rs_i,
    input  logic [ADDR_W-1:0] id_rt_i,
    input  logic              id_use_rs_i,
    input  logic              id_use_rt_i,
    input  logic              id_wen_i,
    input  logic [ADDR_W-1:0] id_waddr_i,
    input  logic              id_is_load_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic [SEL_W-1:0]  fwd_rs_o,
    output logic [SEL_W-1:0]  fwd_rt_o,
    output logic [SEL_W-1:0]  inflight_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    // Tracked entries; index 1 is EX (youngest), index DEPTH is the oldest.
    logic [DEPTH:1]    valid_q;
    logic [DEPTH:1]    wen_q;
    logic [DEPTH:1]    load_q;
    logic [ADDR_W-1:0] waddr_q [1:DEPTH];

    logic [DEPTH:1]    valid_nxt;
    logic [DEPTH:1]    wen_nxt;
    logic [DEPTH:1]    load_nxt;
    logic [ADDR_W-1:0] waddr_nxt [1:DEPTH];

    logic [SEL_W-1:0]  inflight_q;
    logic [SEL_W-1:0]  inflight_nxt;
    logic [CNT_W-1:0]  stall_cnt_q;

    logic [SEL_W-1:0]  rs_sel;
    logic [SEL_W-1:0]  rt_sel;
    logic              rs_haz;
    logic              rt_haz;
    logic              accept;

    // -----------------------------------------------------------------------
    // Operand lookup. Scanning from the oldest stage down to stage 1 lets a
    // younger match overwrite an older one, so the youngest writer wins.
    // A winning load that has not reached LOAD_READY has no forward path.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        rs_sel = '0;
        rt_sel = '0;
        rs_haz = 1'b0;
        rt_haz = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (valid_q[k] && wen_q[k] && id_rs_i != '0 && waddr_q[k] == id_rs_i) begin
                rs_sel = SEL_W'(k);
                rs_haz = load_q[k] && (k < LOAD_READY);
            end
            if (valid_q[k] && wen_q[k] && id_rt_i != '0 && waddr_q[k] == id_rt_i) begin
                rt_sel = SEL_W'(k);
                rt_haz = load_q[k] && (k < LOAD_READY);
            end
        end
    end

    // Reset masks the ID-facing outputs, so stale entries cannot stall or
    // steer the operand muxes before the clearing edge.
    assign stall_o  = !rst_i && id_valid_i && !flush_i &&
                      ((id_use_rs_i && rs_haz) || (id_use_rt_i && rt_haz));
    assign fwd_rs_o = (rst_i || !id_use_rs_i || rs_haz) ? '0 : rs_sel;
    assign fwd_rt_o = (rst_i || !id_use_rt_i || rt_haz) ? '0 : rt_sel;

    // A stalled instruction stays in ID, and a bubble enters stage 1 instead.
    assign accept = id_valid_i && !stall_o && !flush_i;

    // -----------------------------------------------------------------------
    // Next state: shift every stage each cycle. Stage 1 takes the ID
    // instruction or a bubble. A flush clears the younger stages after the
    // shift, so older stages still advance.
    // -----------------------------------------------------------------------
    always_comb begin
        valid_nxt[1] = accept;
        wen_nxt[1]   = id_wen_i;
        load_nxt[1]  = id_is_load_i;
        waddr_nxt[1] = id_waddr_i;
        for (int k = 2; k <= DEPTH; k++) begin
            valid_nxt[k] = valid_q[k-1];
            wen_nxt[k]   = wen_q[k-1];
            load_nxt[k]  = load_q[k-1];
            waddr_nxt[k] = waddr_q[k-1];
        end
        if (flush_i) begin
            for (int k = 1; k <= FLUSH_STAGES; k++) begin
                valid_nxt[k] = 1'b0;
            end
        end
        inflight_nxt = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            inflight_nxt = inflight_nxt + SEL_W'(valid_nxt[k]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q     <= '0;
            inflight_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            valid_q    <= valid_nxt;
            inflight_q <= inflight_nxt;
            if (stall_o && stall_cnt_q != {CNT_W{1'b1}}) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    // NOTE: the payload fields are only meaningful while the matching valid
    // bit is set, so they are not reset. This keeps the field array as plain
    // flops without a reset mux.
    always_ff @(posedge clk_i) begin
        wen_q  <= wen_nxt;
        load_q <= load_nxt;
        for (int k = 1; k <= DEPTH; k++) begin
            waddr_q[k] <= waddr_nxt[k];
        end
    end

    assign inflight_o  = inflight_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule
